// File: rtl/vga_line_fetcher_if.sv
// AXI4 read-address / read-data channel bundle used by vga_line_fetcher.
//   master : the line fetcher (drives AR, accepts R)
//   slave  : the memory / interconnect side
// Signals: araddr, arlen, arsize, arburst, arvalid/arready,
//          rdata, rresp, rlast, rvalid/rready.
interface vga_line_fetcher_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64
);
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/vga_line_fetcher.sv
// vga_line_fetcher: fetches one scanline per request from the DDR framebuffer
// with AXI4 INCR bursts, unpacks each beat into pixels and writes them into
// the idle half of the ping-pong line BRAMs feeding vga_controller.
//
// Ports
//   axi_clk, rst        : single clock, synchronous active-high reset
//   fb_base             : framebuffer base, latched when a line-0 fetch starts
//   vga_ready           : rising edge = display swapped buffers, fetch next line
//   line_ready          : idle buffer holds the next line
//   m_axi               : AXI4 read channels (master modport)
//   wdata/waddr/wren_1  : BRAM_1 write port (pixel addressed)
//   wdata/waddr/wren_2  : BRAM_2 write port (pixel addressed)
//   axi_err             : sticky, some beat returned rresp != OKAY
//   underrun            : sticky, a swap arrived while a fetch was running
//   underrun_cnt        : saturating underrun event count (only with
//                         UNDERRUN_CNT_EN defined)
module vga_line_fetcher #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int BRAM_ADDR_WIDTH = 32,
    parameter int PIXEL_WIDTH     = 16,
    parameter int LINE_PIXELS     = 800,
    parameter int FRAME_LINES     = 600,
    parameter int BURST_LEN       = 8
) (
    input  logic                       axi_clk,
    input  logic                       rst,
    input  logic [AXI_ADDR_WIDTH-1:0]  fb_base,
    input  logic                       vga_ready,
    output logic                       line_ready,
    vga_line_fetcher_if.master         m_axi,
    output logic [PIXEL_WIDTH-1:0]     wdata_1,
    output logic [BRAM_ADDR_WIDTH-1:0] waddr_1,
    output logic                       wren_1,
    output logic [PIXEL_WIDTH-1:0]     wdata_2,
    output logic [BRAM_ADDR_WIDTH-1:0] waddr_2,
    output logic                       wren_2,
    output logic                       axi_err,
    output logic                       underrun
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0]                underrun_cnt
`endif
);
    localparam int PPB         = AXI_DATA_WIDTH / PIXEL_WIDTH;
    localparam int BURST_BYTES = BURST_LEN * AXI_DATA_WIDTH / 8;
    localparam int LINE_BYTES  = LINE_PIXELS * PIXEL_WIDTH / 8;
    localparam int BURSTS      = LINE_PIXELS * PIXEL_WIDTH / (BURST_LEN * AXI_DATA_WIDTH);
    localparam int LW          = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int BIW         = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int BCW         = $clog2(BURST_LEN + 1);
    localparam int KW          = (PPB > 1) ? $clog2(PPB) : 1;

    localparam logic [BCW-1:0] BURST_LEN_C = BCW'(BURST_LEN);
    localparam logic [BIW-1:0] LAST_BURST  = BIW'(BURSTS - 1);
    localparam logic [LW-1:0]  LAST_LINE   = LW'(FRAME_LINES - 1);
    localparam logic [KW-1:0]  LAST_K      = KW'(PPB - 1);

    if ((LINE_PIXELS * PIXEL_WIDTH) % (BURST_LEN * AXI_DATA_WIDTH) != 0) begin : g_geom_check
        $error("vga_line_fetcher: line size is not a whole number of bursts");
    end

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t                     state_q, state_d;
    logic [LW-1:0]              line_idx_q, line_idx_d;
    logic [BIW-1:0]             burst_idx_q, burst_idx_d;
    logic [BCW-1:0]             beat_cnt_q, beat_cnt_d;
    logic [AXI_ADDR_WIDTH-1:0]  base_q, base_d;
    logic [AXI_ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic                       arvalid_q, arvalid_d;
    logic [AXI_DATA_WIDTH-1:0]  pix_buf_q, pix_buf_d;
    logic                       buf_full_q, buf_full_d;
    logic [KW-1:0]              pix_k_q, pix_k_d;
    logic [BRAM_ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [PIXEL_WIDTH-1:0]     wdata_q, wdata_d;
    logic [BRAM_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                       wren_1_q, wren_1_d;
    logic                       wren_2_q, wren_2_d;
    logic                       tgt_q, tgt_d;          // 1 = BRAM_2, 0 = BRAM_1
    logic                       line_ready_q, line_ready_d;
    logic                       pending_q, pending_d;  // one queued fetch request
    logic                       boot_q, boot_d;        // first line after reset
    logic                       vga_ready_q, vga_ready_d;
    logic                       axi_err_q, axi_err_d;
    logic                       underrun_q, underrun_d;
    logic [15:0]                ucnt_q, ucnt_d;

    logic                       rise, rready, r_fire, start;
    logic [AXI_ADDR_WIDTH-1:0]  line_off;
    logic                       unused_rlast;

    assign unused_rlast = m_axi.rlast;  // beat counting decides burst end
    assign rise     = vga_ready && !vga_ready_q;
    // Accept a new beat only when the unpacker frees up this cycle.
    assign rready   = (state_q == R) && (beat_cnt_q != BURST_LEN_C) &&
                      (!buf_full_q || pix_k_q == LAST_K);
    assign r_fire   = m_axi.rvalid && rready;
    assign line_off = AXI_ADDR_WIDTH'(line_idx_q) * AXI_ADDR_WIDTH'(LINE_BYTES);

    always_comb begin
        state_d      = state_q;
        line_idx_d   = line_idx_q;
        burst_idx_d  = burst_idx_q;
        beat_cnt_d   = beat_cnt_q;
        base_d       = base_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        pix_buf_d    = pix_buf_q;
        buf_full_d   = buf_full_q;
        pix_k_d      = pix_k_q;
        wptr_d       = wptr_q;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        wren_1_d     = 1'b0;
        wren_2_d     = 1'b0;
        tgt_d        = tgt_q;
        line_ready_d = line_ready_q;
        pending_d    = pending_q;
        boot_d       = boot_q;
        vga_ready_d  = vga_ready;
        axi_err_d    = axi_err_q;
        underrun_d   = underrun_q;
        ucnt_d       = ucnt_q;
        start        = 1'b0;

        // Unpacker: emit one pixel per cycle from the low end of the beat.
        if (buf_full_q) begin
            wdata_d   = pix_buf_q[PIXEL_WIDTH-1:0];
            waddr_d   = wptr_q;
            wren_1_d  = !tgt_q;
            wren_2_d  = tgt_q;
            pix_buf_d = pix_buf_q >> PIXEL_WIDTH;
            pix_k_d   = pix_k_q + 1'b1;
            wptr_d    = wptr_q + 1'b1;
            if (pix_k_q == LAST_K) buf_full_d = 1'b0;
        end
        if (r_fire) begin
            pix_buf_d  = m_axi.rdata;
            pix_k_d    = '0;
            buf_full_d = 1'b1;
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (m_axi.rresp != 2'b00) axi_err_d = 1'b1;
        end

        case (state_q)
            IDLE: if (pending_q || rise) start = 1'b1;
            AR: if (m_axi.arready) begin
                arvalid_d  = 1'b0;
                beat_cnt_d = '0;
                state_d    = R;
            end
            R: if (beat_cnt_q == BURST_LEN_C) begin
                if (burst_idx_q != LAST_BURST) begin
                    burst_idx_d = burst_idx_q + 1'b1;
                    araddr_d    = araddr_q + AXI_ADDR_WIDTH'(BURST_BYTES);
                    arvalid_d   = 1'b1;
                    state_d     = AR;
                end else if (!buf_full_q) begin
                    // Last pixel has left the unpacker.
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d    = IDLE;
                line_idx_d = (line_idx_q == LAST_LINE) ? '0 : line_idx_q + 1'b1;
                tgt_d      = !tgt_q;
                if (boot_q) begin
                    // Both buffers must be filled before the first display.
                    boot_d    = 1'b0;
                    pending_d = 1'b1;
                end else if (!pending_q) begin
                    line_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rise && state_q != IDLE) begin
            underrun_d = 1'b1;
            pending_d  = 1'b1;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
        end

        if (start) begin
            pending_d    = 1'b0;
            line_ready_d = 1'b0;
            state_d      = AR;
            arvalid_d    = 1'b1;
            burst_idx_d  = '0;
            beat_cnt_d   = '0;
            wptr_d       = '0;
            // New base only at a frame boundary.
            if (line_idx_q == '0) begin
                base_d   = fb_base;
                araddr_d = fb_base + line_off;
            end else begin
                araddr_d = base_q + line_off;
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_idx_q   <= '0;
            burst_idx_q  <= '0;
            beat_cnt_q   <= '0;
            base_q       <= '0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            pix_buf_q    <= '0;
            buf_full_q   <= 1'b0;
            pix_k_q      <= '0;
            wptr_q       <= '0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            wren_1_q     <= 1'b0;
            wren_2_q     <= 1'b0;
            tgt_q        <= 1'b1;
            line_ready_q <= 1'b0;
            pending_q    <= 1'b1;
            boot_q       <= 1'b1;
            vga_ready_q  <= 1'b1;
            axi_err_q    <= 1'b0;
            underrun_q   <= 1'b0;
            ucnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            line_idx_q   <= line_idx_d;
            burst_idx_q  <= burst_idx_d;
            beat_cnt_q   <= beat_cnt_d;
            base_q       <= base_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            pix_buf_q    <= pix_buf_d;
            buf_full_q   <= buf_full_d;
            pix_k_q      <= pix_k_d;
            wptr_q       <= wptr_d;
            wdata_q      <= wdata_d;
            waddr_q      <= waddr_d;
            wren_1_q     <= wren_1_d;
            wren_2_q     <= wren_2_d;
            tgt_q        <= tgt_d;
            line_ready_q <= line_ready_d;
            pending_q    <= pending_d;
            boot_q       <= boot_d;
            vga_ready_q  <= vga_ready_d;
            axi_err_q    <= axi_err_d;
            underrun_q   <= underrun_d;
            ucnt_q       <= ucnt_d;
        end
    end

    assign m_axi.araddr  = araddr_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.arlen   = 8'(BURST_LEN - 1);
    assign m_axi.arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign m_axi.arburst = 2'b01;
    assign m_axi.rready  = rready;

    assign line_ready = line_ready_q;
    assign wdata_1    = wdata_q;
    assign waddr_1    = waddr_q;
    assign wren_1     = wren_1_q;
    assign wdata_2    = wdata_q;
    assign waddr_2    = waddr_q;
    assign wren_2     = wren_2_q;
    assign axi_err    = axi_err_q;
    assign underrun   = underrun_q;

`ifdef UNDERRUN_CNT_EN
    assign underrun_cnt = ucnt_q;
`else
    logic [15:0] unused_ucnt;
    assign unused_ucnt = ucnt_q;
`endif
endmodule

// File: tb/tb_vga_line_fetcher.sv
// Bench for vga_line_fetcher: an AXI read slave backed by an address-derived
// pixel pattern, a scoreboard of expected AR addresses and BRAM writes, and a
// monitor that retires scoreboard entries as the DUT produces them.
// FRAME_LINES is reduced to 4 so frame wrap-around happens within a short run.
module tb_vga_line_fetcher;
    localparam int LINES = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fb_base = 32'h1000_0000;
    logic        vga_ready = 1'b0;
    logic        line_ready;
    logic [15:0] wdata_1, wdata_2;
    logic [31:0] waddr_1, waddr_2;
    logic        wren_1, wren_2, axi_err, underrun;
`ifdef UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    vga_line_fetcher_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)) m_axi ();

    vga_line_fetcher #(.FRAME_LINES(LINES)) dut (
        .axi_clk(clk), .rst(rst), .fb_base(fb_base), .vga_ready(vga_ready),
        .line_ready(line_ready), .m_axi(m_axi),
        .wdata_1(wdata_1), .waddr_1(waddr_1), .wren_1(wren_1),
        .wdata_2(wdata_2), .waddr_2(waddr_2), .wren_2(wren_2),
        .axi_err(axi_err), .underrun(underrun)
`ifdef UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  bram;
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    int          nwrites = 0;
    wr_t         exp_w[$];
    logic [31:0] exp_ar[$];
    bit          stall_en = 1'b0;
    int          err_req = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Memory content: pixel value derived from its byte address.
    function automatic logic [15:0] pix(input logic [31:0] a);
        logic [15:0] v;
        v = a[16:1] + 16'd1;
        if (a[29]) v = v ^ 16'h8000;
        return v;
    endfunction

    function automatic logic [63:0] beat(input logic [31:0] a);
        logic [63:0] d;
        for (int k = 0; k < 4; k++) d[k*16 +: 16] = pix(a + 32'(2 * k));
        return d;
    endfunction

    task automatic push_line(input logic [31:0] start, input logic [1:0] bram);
        for (int b = 0; b < 25; b++) exp_ar.push_back(start + 32'(b * 64));
        for (int p = 0; p < 800; p++) begin
            wr_t w;
            w.bram = bram;
            w.addr = 32'(p);
            w.data = pix(start + 32'(2 * p));
            exp_w.push_back(w);
        end
    endtask

    task automatic pulse();
        @(negedge clk) vga_ready = 1'b1;
        @(negedge clk) vga_ready = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int budget);
        int n;
        n = 0;
        while (line_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(line_ready), 64'd1);
    endtask

    // AXI read slave
    initial begin
        logic        ar_hs, r_hs, rs;
        logic [31:0] a, cur;
        logic [31:0] pend[$];
        int          left, err_done;
        cur = 0; left = 0; err_done = 0;
        m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rdata = '0;
        m_axi.rresp = 2'b00; m_axi.rlast = 1'b0;
        forever begin
            @(posedge clk);
            ar_hs = m_axi.arvalid && m_axi.arready;
            a     = m_axi.araddr;
            r_hs  = m_axi.rvalid && m_axi.rready;
            rs    = rst;
            #1;
            if (rs) begin
                pend.delete();
                left = 0;
                err_done = err_req;
                m_axi.rvalid = 1'b0; m_axi.arready = 1'b0;
                m_axi.rlast = 1'b0; m_axi.rresp = 2'b00;
            end else begin
                if (ar_hs) pend.push_back(a);
                if (r_hs) begin
                    cur = cur + 32'd8;
                    left--;
                    m_axi.rvalid = 1'b0;
                end
                if (left == 0 && pend.size() > 0) begin
                    cur = pend.pop_front();
                    left = 8;
                end
                if (left > 0 && !m_axi.rvalid && (!stall_en || $urandom_range(0, 1) == 1)) begin
                    m_axi.rvalid = 1'b1;
                    m_axi.rdata  = beat(cur);
                    m_axi.rlast  = (left == 1);
                    m_axi.rresp  = (err_done != err_req) ? 2'b10 : 2'b00;
                    err_done     = err_req;
                end
                m_axi.arready = !stall_en || ($urandom_range(0, 1) == 1);
            end
        end
    end

    // Monitor: retire expected AR addresses and BRAM writes.
    initial begin
        forever begin
            @(negedge clk);
            if (wren_1 || wren_2) begin
                nwrites++;
                if (exp_w.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: wren=%b%b addr=%0h", wren_1, wren_2, wren_1 ? waddr_1 : waddr_2);
                end else begin
                    wr_t e;
                    e = exp_w.pop_front();
                    check("wr_target", {wren_1, wren_2}, (e.bram == 2'd1) ? 64'd2 : 64'd1);
                    check("wr_addr", (e.bram == 2'd1) ? waddr_1 : waddr_2, e.addr);
                    check("wr_data", (e.bram == 2'd1) ? wdata_1 : wdata_2, e.data);
                end
            end
            if (m_axi.arvalid && m_axi.arready) begin
                check("ar_attr", {m_axi.arlen, m_axi.arsize, m_axi.arburst}, {8'd7, 3'd3, 2'b01});
                if (exp_ar.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ar: addr=%0h", m_axi.araddr);
                end else begin
                    check("ar_addr", m_axi.araddr, exp_ar.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outs", {line_ready, m_axi.arvalid, m_axi.rready, wren_1, wren_2, axi_err, underrun}, 64'd0);
        check("reset_araddr", m_axi.araddr, 64'd0);
        check("reset_wr", {wdata_1, waddr_1, wdata_2, waddr_2}, 64'd0);

        // Boot: line 0 -> BRAM_2, line 1 -> BRAM_1.
        push_line(32'h1000_0000, 2'd2);
        push_line(32'h1000_0640, 2'd1);
        rst = 1'b0;
        wait_ready("boot_ready", 6000);
        check("boot_writes", nwrites, 64'd1600);
        check("boot_drain", exp_w.size() + exp_ar.size(), 64'd0);

        // Swap: line 2 -> BRAM_2.
        push_line(32'h1000_0C80, 2'd2);
        pulse();
        check("swap_clears_ready", line_ready, 64'd0);
        wait_ready("line2_ready", 3000);
        check("line2_drain", exp_w.size() + exp_ar.size(), 64'd0);

        // Base change mid-frame: line 3 keeps old base, line 0 picks new one.
        fb_base = 32'h2000_0000;
        push_line(32'h1000_12C0, 2'd1);
        pulse();
        wait_ready("line3_ready", 3000);
        push_line(32'h2000_0000, 2'd2);
        pulse();
        wait_ready("newbase_line0_ready", 3000);
        push_line(32'h2000_0640, 2'd1);
        pulse();
        wait_ready("newbase_line1_ready", 3000);
        check("frame_drain", exp_w.size() + exp_ar.size(), 64'd0);

        // Stalls plus a swap arriving mid-fetch.
        stall_en = 1'b1;
        push_line(32'h2000_0C80, 2'd2);
        pulse();
        check("stall_swap_clears_ready", line_ready, 64'd0);
        repeat (100) @(negedge clk);
        check("no_underrun_yet", underrun, 64'd0);
        push_line(32'h2000_12C0, 2'd1);
        pulse();
        check("underrun_set", underrun, 64'd1);
`ifdef UNDERRUN_CNT_EN
        check("underrun_cnt", underrun_cnt, 64'd1);
`endif
        wait_ready("queued_ready", 12000);
        check("queued_drain", exp_w.size() + exp_ar.size(), 64'd0);
        check("underrun_sticky", underrun, 64'd1);

        // Error response on one beat, then reset mid-burst.
        push_line(32'h2000_0000, 2'd2);
        pulse();
        repeat (40) @(negedge clk);
        check("no_err_yet", axi_err, 64'd0);
        err_req++;
        repeat (100) @(negedge clk);
        check("axi_err_set", axi_err, 64'd1);
        repeat (100) @(negedge clk);
        check("axi_err_sticky", axi_err, 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_w.delete();
        exp_ar.delete();
        @(negedge clk);
        check("midburst_reset_outs", {line_ready, m_axi.arvalid, m_axi.rready, wren_1, wren_2, axi_err, underrun}, 64'd0);
`ifdef UNDERRUN_CNT_EN
        check("reset_underrun_cnt", underrun_cnt, 64'd0);
`endif

        // Restart from line 0 with a new base.
        fb_base = 32'h3000_0000;
        push_line(32'h3000_0000, 2'd2);
        push_line(32'h3000_0640, 2'd1);
        @(negedge clk) rst = 1'b0;
        wait_ready("restart_ready", 12000);
        check("restart_drain", exp_w.size() + exp_ar.size(), 64'd0);
        check("restart_flags", {axi_err, underrun}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
